conv10_sched: RTL and testbench

CONV10_SCHED -- requirements
Module: conv10_sched

---
 rtl/conv10_sched_pkg.sv | 18 +
 rtl/conv10_addr_gen.sv | 66 ++++++
 rtl/conv10_sched.sv | 144 ++++++++++++++
 tb/tb_conv10_sched.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv10_sched_pkg.sv
// Shared state encoding and width helper for the conv10 two-layer scheduler.
// Optional cycle counters are enabled in the top with CONV10_SCHED_PERF_EN.
package conv10_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN1     = 3'd1,
        ST_GAP_WAIT = 3'd2,
        ST_RUN2     = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // Address width for a range of `count` values, never narrower than one bit.
    function automatic int width_of(input int count);
        return (count <= 1) ? 1 : $clog2(count);
    endfunction

endpackage

// File: rtl/conv10_addr_gen.sv
// Channel, ifm read-address and ofm write-address counters for the conv10 scheduler.
module conv10_addr_gen
    import conv10_sched_pkg::*;
#(
    parameter int WOUT = 8,
    parameter int CHIN = 736,
    localparam int IFM_W = width_of(CHIN * WOUT * WOUT),
    localparam int OFM_W = width_of(WOUT * WOUT) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    input  logic             wr_en,
    input  logic             layer_sel,
    output logic [IFM_W-1:0] ifm_rd_addr,
    output logic [OFM_W-1:0] ofm_wr_addr
);

    localparam int CH_W  = width_of(CHIN + 1);
    localparam int LOW_W = OFM_W - 1;
    localparam logic [IFM_W-1:0] IFM_MAX = IFM_W'(CHIN * WOUT * WOUT - 1);
    localparam logic [CH_W-1:0]  CH_LAST = CH_W'(CHIN);

    logic [CH_W-1:0]  chan_q, chan_d;
    logic [IFM_W-1:0] ifm_q, ifm_d;
    logic [LOW_W-1:0] ofm_q, ofm_d;

    always_comb begin
        chan_d = chan_q;
        ifm_d  = ifm_q;
        ofm_d  = ofm_q;
        if (clear) begin
            chan_d = '0;
            ifm_d  = '0;
            ofm_d  = '0;
        end else begin
            if (advance) begin
                chan_d = (chan_q == CH_LAST) ? '0 : chan_q + 1'b1;
                // The datapath clear-bubble slot re-presents the previous address.
                if ((chan_d != CH_LAST) && (ifm_q != IFM_MAX)) begin
                    ifm_d = ifm_q + 1'b1;
                end
            end
            if (wr_en) begin
                ofm_d = ofm_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chan_q <= '0;
            ifm_q  <= '0;
            ofm_q  <= '0;
        end else begin
            chan_q <= chan_d;
            ifm_q  <= ifm_d;
            ofm_q  <= ofm_d;
        end
    end

    assign ifm_rd_addr = ifm_q;
    assign ofm_wr_addr = {layer_sel, ofm_q};

endmodule

// File: rtl/conv10_sched.sv
// Two-layer conv10 sequencer: RUN1, a fixed idle gap, RUN2, then a one-cycle done.
// Define CONV10_SCHED_PERF_EN to add the cyc_l1/cyc_l2 per-layer cycle counters.
module conv10_sched
    import conv10_sched_pkg::*;
#(
    parameter int WOUT = 8,
    parameter int CHIN = 736,
    parameter int GAP  = 2,
    localparam int IFM_W = width_of(CHIN * WOUT * WOUT),
    localparam int OFM_W = width_of(WOUT * WOUT) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             conv10_1_finish,
    input  logic             conv10_2_finish,
    input  logic             sample,
    output logic             conv10_1_en,
    output logic             conv10_2_en,
    output logic             ram_feedback_1,
    output logic             ram_feedback_2,
    output logic [IFM_W-1:0] ifm_rd_addr,
    output logic [OFM_W-1:0] ofm_wr_addr,
    output logic             ofm_wr_en,
    output logic             layer_sel,
    output logic             busy,
    output logic             done
`ifdef CONV10_SCHED_PERF_EN
    ,
    output logic [31:0]      cyc_l1,
    output logic [31:0]      cyc_l2
`endif
);

    localparam int GAP_W = width_of(GAP + 1);

    state_t           state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             enter_run;

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        enter_run = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN1;
                    enter_run = 1'b1;
                end
            end
            ST_RUN1: begin
                if (conv10_1_finish) begin
                    if (GAP == 0) begin
                        state_d   = ST_RUN2;
                        enter_run = 1'b1;
                    end else begin
                        state_d = ST_GAP_WAIT;
                        gap_d   = '0;
                    end
                end
            end
            ST_GAP_WAIT: begin
                if (int'(gap_q) + 1 >= GAP) begin
                    state_d   = ST_RUN2;
                    enter_run = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ST_RUN2: begin
                if (conv10_2_finish) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    // Everything is decoded from the registered state so reset zeroes all outputs at once.
    assign busy           = (state_q != ST_IDLE);
    assign conv10_1_en    = (state_q == ST_RUN1);
    assign conv10_2_en    = (state_q == ST_RUN2);
    assign done           = (state_q == ST_DONE);
    assign layer_sel      = (state_q == ST_RUN2) || (state_q == ST_DONE);
    assign ram_feedback_1 = conv10_1_en & conv10_1_finish;
    assign ram_feedback_2 = conv10_2_en & conv10_2_finish;
    assign ofm_wr_en      = sample & busy;

    conv10_addr_gen #(
        .WOUT (WOUT),
        .CHIN (CHIN)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .clear       (enter_run),
        .advance     (conv10_1_en | conv10_2_en),
        .wr_en       (ofm_wr_en),
        .layer_sel   (layer_sel),
        .ifm_rd_addr (ifm_rd_addr),
        .ofm_wr_addr (ofm_wr_addr)
    );

`ifdef CONV10_SCHED_PERF_EN
    logic [31:0] cyc_l1_q, cyc_l1_d, cyc_l2_q, cyc_l2_d;

    always_comb begin
        cyc_l1_d = cyc_l1_q;
        cyc_l2_d = cyc_l2_q;
        if ((state_q == ST_IDLE) && start) begin
            cyc_l1_d = '0;
            cyc_l2_d = '0;
        end else begin
            if (conv10_1_en) cyc_l1_d = cyc_l1_q + 32'd1;
            if (conv10_2_en) cyc_l2_d = cyc_l2_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_l1_q <= '0;
            cyc_l2_q <= '0;
        end else begin
            cyc_l1_q <= cyc_l1_d;
            cyc_l2_q <= cyc_l2_d;
        end
    end

    assign cyc_l1 = cyc_l1_q;
    assign cyc_l2 = cyc_l2_q;
`endif

endmodule

// File: tb/tb_conv10_sched.sv
// Self-checking bench for conv10_sched (WOUT=2, CHIN=4, GAP=2): directed sequences
// with literal expectations plus randomized traffic against a behavioural model.
module tb_conv10_sched;

    localparam int WOUT    = 2;
    localparam int CHIN    = 4;
    localparam int GAP     = 2;
    localparam int PIX     = WOUT * WOUT;
    localparam int IFM_MAX = CHIN * PIX - 1;

    localparam int MP_IDLE = 0;
    localparam int MP_RUN1 = 1;
    localparam int MP_GAP  = 2;
    localparam int MP_RUN2 = 3;
    localparam int MP_DONE = 4;

    logic       clk;
    logic       rst;
    logic       start;
    logic       conv10_1_finish;
    logic       conv10_2_finish;
    logic       sample;
    logic       conv10_1_en;
    logic       conv10_2_en;
    logic       ram_feedback_1;
    logic       ram_feedback_2;
    logic [3:0] ifm_rd_addr;
    logic [2:0] ofm_wr_addr;
    logic       ofm_wr_en;
    logic       layer_sel;
    logic       busy;
    logic       done;

    int testsRun = 0;
    int failures = 0;

    int mPhase = MP_IDLE;
    int mSlot = 0;
    int mWrites = 0;
    int mGap = 0;

    logic [7:0] actCtrl;
    logic [7:0] expCtrl;
    logic       expBusy;
    logic       expLayer;
    logic       expWr;

    int ifmSeq[22] = '{0, 1, 2, 3, 3, 4, 5, 6, 7, 7, 8, 9, 10, 11, 11, 12, 13, 14, 15, 15, 15, 15};
    int fbCount;
    int doneCount;

    conv10_sched #(
        .WOUT (WOUT),
        .CHIN (CHIN),
        .GAP  (GAP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .conv10_1_finish (conv10_1_finish),
        .conv10_2_finish (conv10_2_finish),
        .sample          (sample),
        .conv10_1_en     (conv10_1_en),
        .conv10_2_en     (conv10_2_en),
        .ram_feedback_1  (ram_feedback_1),
        .ram_feedback_2  (ram_feedback_2),
        .ifm_rd_addr     (ifm_rd_addr),
        .ofm_wr_addr     (ofm_wr_addr),
        .ofm_wr_en       (ofm_wr_en),
        .layer_sel       (layer_sel),
        .busy            (busy),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, return at the falling edge.
    task automatic applyStimulus(input logic rstV, input logic startV, input logic f1V,
                                 input logic f2V, input logic sampleV);
        @(posedge clk);
        #1;
        rst             = rstV;
        start           = startV;
        conv10_1_finish = f1V;
        conv10_2_finish = f2V;
        sample          = sampleV;
        @(negedge clk);
    endtask

    // Address after k running cycles: one step per cycle except each (CHIN+1)-th slot.
    function automatic int expectedIfm(input int k);
        int a;
        a = k - (k + 1) / (CHIN + 1);
        return (a > IFM_MAX) ? IFM_MAX : a;
    endfunction

    // Behavioural model and per-cycle comparison.
    always @(negedge clk) begin
        actCtrl = {busy, done, conv10_1_en, conv10_2_en, ram_feedback_1, ram_feedback_2,
                   layer_sel, ofm_wr_en};
        if (rst) begin
            checkOutput("reset_ctrl", 32'(actCtrl), 32'd0);
            checkOutput("reset_ifm", 32'(ifm_rd_addr), 32'd0);
            checkOutput("reset_ofm", 32'(ofm_wr_addr), 32'd0);
            mPhase  = MP_IDLE;
            mSlot   = 0;
            mWrites = 0;
            mGap    = 0;
        end else begin
            expBusy  = (mPhase != MP_IDLE);
            expLayer = (mPhase == MP_RUN2) || (mPhase == MP_DONE);
            expWr    = sample && expBusy;
            expCtrl  = {expBusy, mPhase == MP_DONE, mPhase == MP_RUN1, mPhase == MP_RUN2,
                        (mPhase == MP_RUN1) && conv10_1_finish,
                        (mPhase == MP_RUN2) && conv10_2_finish, expLayer, expWr};
            checkOutput("model_ctrl", 32'(actCtrl), 32'(expCtrl));
            checkOutput("model_ofm", 32'(ofm_wr_addr), 32'((expLayer ? PIX : 0) + mWrites % PIX));
            if ((mPhase == MP_RUN1) || (mPhase == MP_RUN2)) begin
                checkOutput("model_ifm", 32'(ifm_rd_addr), 32'(expectedIfm(mSlot)));
            end
            if (expWr) mWrites++;
            case (mPhase)
                MP_IDLE: if (start) begin
                    mPhase = MP_RUN1; mSlot = 0; mWrites = 0;
                end
                MP_RUN1: if (conv10_1_finish) begin
                    mPhase = MP_GAP; mGap = 0;
                end else mSlot++;
                MP_GAP: begin
                    mGap++;
                    if (mGap == GAP) begin
                        mPhase = MP_RUN2; mSlot = 0; mWrites = 0;
                    end
                end
                MP_RUN2: if (conv10_2_finish) mPhase = MP_DONE; else mSlot++;
                default: mPhase = MP_IDLE;
            endcase
        end
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        conv10_1_finish = 1'b0;
        conv10_2_finish = 1'b0;
        sample = 1'b0;

        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ifm", 32'(ifm_rd_addr), 32'd0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("idle_wr_en", 32'(ofm_wr_en), 32'd0);

        // Layer 1: address walk with saturation, a stray start and three writes.
        applyStimulus(0, 1, 0, 0, 0);
        for (int i = 0; i < 22; i++) begin
            applyStimulus(0, i == 6, 0, 0, (i == 10) || (i == 12) || (i == 14));
            checkOutput("run1_ifm", 32'(ifm_rd_addr), 32'(ifmSeq[i]));
            checkOutput("run1_en2", 32'(conv10_2_en), 32'd0);
            checkOutput("run1_ofm", 32'(ofm_wr_addr), 32'((i <= 10) ? 0 : (i <= 12) ? 1 : (i <= 14) ? 2 : 3));
        end
        applyStimulus(0, 0, 1, 0, 1);
        checkOutput("fin1_wr_en", 32'(ofm_wr_en), 32'd1);
        checkOutput("fin1_ofm", 32'(ofm_wr_addr), 32'd3);
        checkOutput("fin1_fb1", 32'(ram_feedback_1), 32'd1);
        for (int i = 0; i < GAP; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput("gap_ens", 32'({conv10_1_en, conv10_2_en, ram_feedback_1}), 32'd0);
            checkOutput("gap_busy", 32'(busy), 32'd1);
        end
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("run2_en2", 32'(conv10_2_en), 32'd1);
        checkOutput("run2_ofm", 32'(ofm_wr_addr), 32'd4);
        checkOutput("run2_ifm", 32'(ifm_rd_addr), 32'd0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 1'($urandom_range(0, 1)));

        // Layer 2 finish held high: single feedback and single done.
        fbCount = 0;
        doneCount = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 1, 0);
            fbCount += int'(ram_feedback_2);
            doneCount += int'(done);
        end
        checkOutput("fin2_fb2_count", 32'(fbCount), 32'd1);
        checkOutput("fin2_done_count", 32'(doneCount), 32'd1);
        checkOutput("fin2_busy", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of layer 2, then a clean restart.
        applyStimulus(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        for (int i = 0; i < GAP + 3; i++) applyStimulus(0, 0, 0, 0, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_ctrl", 32'({busy, conv10_2_en, layer_sel, ofm_wr_en}), 32'd0);
        checkOutput("async_ifm", 32'(ifm_rd_addr), 32'd0);
        checkOutput("async_ofm", 32'(ofm_wr_addr), 32'd0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("post_rst_idle", 32'(busy), 32'd0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("restart_en1", 32'(conv10_1_en), 32'd1);
        checkOutput("restart_ifm0", 32'(ifm_rd_addr), 32'd0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("restart_ifm1", 32'(ifm_rd_addr), 32'd1);

        // Randomized traffic checked by the model.
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(($urandom % 200) == 0, ($urandom % 6) == 0, ($urandom % 10) == 0,
                          ($urandom % 10) == 0, ($urandom % 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
